// File: rtl/sevenseg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sevenseg_pkg                                                         |
// | Shared constants and types for the seven-segment display arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sevenseg_pkg;

  localparam int NREQ          = 4;
  localparam int OWNER_W       = 2;
  localparam int DWELL_DEFAULT = 50000000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational 4-way round-robin picker; masked requesters are skipped|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick
  import sevenseg_pkg::*;
(
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  input  logic [NREQ-1:0]    mask,
  output logic               found,
  output logic [OWNER_W-1:0] idx
);

  logic [NREQ-1:0]    w_elig;
  logic [OWNER_W-1:0] w_cand;

  assign w_elig = req & ~mask;

  // Walk from ptr upward with wrap; the first eligible bit wins.
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = ptr + OWNER_W'(i);
      if (!found && w_elig[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sevenseg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sevenseg_arbiter                                                     |
// | Round-robin display sharing with a minimum dwell time per owner.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sevenseg_arbiter
  import sevenseg_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int CNT_W = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [15:0]          disp_data,
  output logic [OWNER_W-1:0]   owner,
  output logic                 owner_valid,
  output logic                 busy
);

  localparam int               c_DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] c_LOAD      = CNT_W'(c_DWELL_EFF - 1);
  localparam logic [CNT_W-1:0] c_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               r_state,  w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic [15:0]          r_disp,   w_disp_nxt;
  logic [OWNER_W-1:0]   r_owner,  w_owner_nxt;
  logic [OWNER_W-1:0]   r_ptr,    w_ptr_nxt;
  logic [NREQ-1:0]      r_ack,    w_ack_nxt;

  logic [NREQ-1:0]      w_mask;
  logic                 w_found;
  logic [OWNER_W-1:0]   w_idx;
  logic [15:0]          w_pick_word;
  logic [15:0]          w_owner_word;

  // Owner is only excluded at dwell expiry; in IDLE every requester competes.
  assign w_mask       = (r_state == HOLD) ? onehot(r_owner) : '0;
  assign w_pick_word  = req_data[{w_idx, 4'b0000} +: 16];
  assign w_owner_word = req_data[{r_owner, 4'b0000} +: 16];

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .mask  (w_mask),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_disp  <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_disp  <= w_disp_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_disp_nxt  = r_disp;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_ack_nxt   = '0;
    if ((r_state == HOLD) && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - c_ONE;
      if (req[r_owner]) begin
        w_disp_nxt = w_owner_word;
        w_ack_nxt  = onehot(r_owner);
      end
    end else if (w_found) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = c_LOAD;
      w_disp_nxt  = w_pick_word;
      w_owner_nxt = w_idx;
      w_ptr_nxt   = w_idx + OWNER_W'(1);
      w_ack_nxt   = onehot(w_idx);
    end else if ((r_state == HOLD) && req[r_owner]) begin
      w_cnt_nxt  = c_LOAD;
      w_disp_nxt = w_owner_word;
      w_ack_nxt  = onehot(r_owner);
    end else begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    ack         = r_ack;
    disp_data   = r_disp;
    owner       = r_owner;
    owner_valid = (r_state == HOLD);
    busy        = (r_state == HOLD);
  end

endmodule
`default_nettype wire
